// File: rtl/mesi_bus_pkg.sv
// Shared types for the MESI snooping bus: bus commands, controller states and
// the per-cache command priority encoder.
package mesi_bus_pkg;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_RD,
    CMD_RDX,
    CMD_UPGR
  } bus_cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    SNOOP,
    RESP,
    WB,
    FILL,
    DONE
  } bus_state_e;

  // A cache raising several request bits at once is served as the strongest one.
  function automatic bus_cmd_e cmd_sel(input logic rd, input logic rdx, input logic upgr);
    if (rdx)       return CMD_RDX;
    else if (upgr) return CMD_UPGR;
    else if (rd)   return CMD_RD;
    return CMD_NONE;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mesi_snoop_bus_if.sv
// Cache-side and memory-side signals of the snooping bus. The master modport is
// the environment (cache controllers plus memory), the slave modport the bus.
interface mesi_snoop_bus_if #(
  parameter int NUM_CACHES = 4,
  parameter int ADDR_W     = 32
);
  logic [NUM_CACHES-1:0]        BusRd_out;
  logic [NUM_CACHES-1:0]        BusRdX_out;
  logic [NUM_CACHES-1:0]        BusUpgr_out;
  logic [NUM_CACHES*ADDR_W-1:0] req_addr;
  logic [NUM_CACHES-1:0]        snoop_hit;
  logic [NUM_CACHES-1:0]        Flush;
  logic [NUM_CACHES-1:0]        BusRd_in;
  logic [NUM_CACHES-1:0]        BusRdX_in;
  logic [NUM_CACHES-1:0]        BusUpgr_in;
  logic [ADDR_W-1:0]            snoop_addr;
  logic [NUM_CACHES-1:0]        C_in;
  logic [NUM_CACHES-1:0]        done;
  logic                         mem_rd_req;
  logic                         mem_wr_req;
  logic [ADDR_W-1:0]            mem_addr;
  logic                         mem_ack;

  modport master (
    output BusRd_out, BusRdX_out, BusUpgr_out, req_addr, snoop_hit, Flush, mem_ack,
    input  BusRd_in, BusRdX_in, BusUpgr_in, snoop_addr, C_in, done,
           mem_rd_req, mem_wr_req, mem_addr
  );

  modport slave (
    input  BusRd_out, BusRdX_out, BusUpgr_out, req_addr, snoop_hit, Flush, mem_ack,
    output BusRd_in, BusRdX_in, BusUpgr_in, snoop_addr, C_in, done,
           mem_rd_req, mem_wr_req, mem_addr
  );
endinterface

// File: rtl/mesi_rr_arbiter.sv
// Round-robin arbiter: searches upward from ptr (wrapping) for the first active
// request and returns it as one-hot grant plus index.
module mesi_rr_arbiter
  import mesi_bus_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             valid
);

  // NOTE: every output gets a default before the search loop so no path leaves
  // it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!valid && req[IDX_W'((int'(ptr) + i) % N)]) begin
        valid     = 1'b1;
        grant_idx = IDX_W'((int'(ptr) + i) % N);
        grant[IDX_W'((int'(ptr) + i) % N)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mesi_snoop_bus.sv
// Shared snooping bus for MESI caches: round-robin arbitration, broadcast,
// shared/flush collection and memory writeback/fill sequencing.
// Optional macro CACHE_TO_CACHE_EN: a flushed line goes straight to the requester.
module mesi_snoop_bus
  import mesi_bus_pkg::*;
#(
  parameter int NUM_CACHES = 4,
  parameter int ADDR_W     = 32
) (
  input logic              clk,
  input logic              rstb,
  mesi_snoop_bus_if.slave  bus
);

  localparam int IDX_W = idx_w(NUM_CACHES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CACHES - 1);

  bus_state_e              state, state_nxt;
  logic [IDX_W-1:0]        rr_ptr;
  logic [NUM_CACHES-1:0]   grant_oh;
  bus_cmd_e                cmd;
  logic [ADDR_W-1:0]       addr;
  logic                    shared_q;
  logic                    c_shared;

  logic [NUM_CACHES-1:0]   req_any;
  logic [NUM_CACHES-1:0]   arb_grant;
  logic [IDX_W-1:0]        arb_idx;
  logic                    arb_valid;
  logic                    resp_shared;
  logic                    resp_flush;
  logic [ADDR_W-1:0]       req_addr_arr [NUM_CACHES];

  assign req_any     = bus.BusRd_out | bus.BusRdX_out | bus.BusUpgr_out;
  assign resp_shared = |(bus.snoop_hit & ~grant_oh);
  assign resp_flush  = |(bus.Flush & ~grant_oh);

  always_comb begin
    for (int i = 0; i < NUM_CACHES; i++) begin
      req_addr_arr[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  mesi_rr_arbiter #(
    .N     (NUM_CACHES),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (req_any),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .valid     (arb_valid)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rr_ptr   <= '0;
      grant_oh <= '0;
      cmd      <= CMD_NONE;
      addr     <= '0;
      shared_q <= 1'b0;
    end else begin
      if (state == ARB && arb_valid) begin
        grant_oh <= arb_grant;
        cmd      <= cmd_sel(bus.BusRd_out[arb_idx], bus.BusRdX_out[arb_idx],
                            bus.BusUpgr_out[arb_idx]);
        addr     <= req_addr_arr[arb_idx];
        rr_ptr   <= (arb_idx == LAST_IDX) ? '0 : arb_idx + IDX_W'(1);
      end
      if (state == RESP) shared_q <= resp_shared;
    end
  end

`ifdef CACHE_TO_CACHE_EN
  logic flush_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)               flush_q <= 1'b0;
    else if (state == RESP)  flush_q <= resp_flush;
  end

  // The flushing cache keeps a shared copy, so the requester must enter S.
  assign c_shared = shared_q | flush_q;
`else
  assign c_shared = shared_q;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (|req_any) state_nxt = ARB;
      ARB:   state_nxt = arb_valid ? SNOOP : IDLE;
      SNOOP: state_nxt = RESP;
      RESP: begin
        if (cmd == CMD_UPGR) state_nxt = DONE;
        else if (resp_flush) state_nxt = WB;
        else                 state_nxt = FILL;
      end
      WB: begin
`ifdef CACHE_TO_CACHE_EN
        if (bus.mem_ack) state_nxt = DONE;
`else
        if (bus.mem_ack) state_nxt = FILL;
`endif
      end
      FILL:    if (bus.mem_ack) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.BusRd_in   = '0;
    bus.BusRdX_in  = '0;
    bus.BusUpgr_in = '0;
    bus.snoop_addr = '0;
    bus.C_in       = '0;
    bus.done       = '0;
    bus.mem_rd_req = 1'b0;
    bus.mem_wr_req = 1'b0;
    bus.mem_addr   = '0;
    case (state)
      SNOOP: begin
        bus.snoop_addr = addr;
        case (cmd)
          CMD_RD:   bus.BusRd_in   = ~grant_oh;
          CMD_RDX:  bus.BusRdX_in  = ~grant_oh;
          CMD_UPGR: bus.BusUpgr_in = ~grant_oh;
          default:  ;
        endcase
      end
      WB: begin
        bus.mem_wr_req = 1'b1;
        bus.mem_addr   = addr;
      end
      FILL: begin
        bus.mem_rd_req = 1'b1;
        bus.mem_addr   = addr;
      end
      DONE: begin
        bus.done = grant_oh;
        // Exclusive ownership requests always complete unshared.
        if (cmd == CMD_RD && c_shared) bus.C_in = grant_oh;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mesi_snoop_bus.sv
// Scoreboard bench for mesi_snoop_bus: stimulus pushes expected broadcasts,
// memory operations and completions; independent monitors pop and compare.
module tb_mesi_snoop_bus;
  import mesi_bus_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
`ifdef CACHE_TO_CACHE_EN
  localparam bit C2C = 1'b1;
`else
  localparam bit C2C = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  mesi_snoop_bus_if #(.NUM_CACHES(N), .ADDR_W(AW)) bus ();

  mesi_snoop_bus #(.NUM_CACHES(N), .ADDR_W(AW)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  typedef struct { logic [N-1:0] done_v; logic [N-1:0] c_v; int cyc; } done_t;
  typedef struct { logic [N-1:0] rd_v; logic [N-1:0] rdx_v; logic [N-1:0] upgr_v;
                   logic [AW-1:0] addr; } bcast_t;
  typedef struct { logic is_wr; logic [AW-1:0] addr; int cycles; } mem_t;

  done_t  done_q  [$];
  bcast_t bcast_q [$];
  mem_t   mem_q   [$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int mem_lat = 3;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: acks after the request has been visible for mem_lat cycles.
  initial begin
    int cnt = 0;
    logic [1:0] kind, prev;
    prev = 2'b00;
    bus.mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      kind = {bus.mem_wr_req, bus.mem_rd_req};
      if (kind == 2'b00) begin
        cnt = 0;
        bus.mem_ack = 1'b0;
      end else begin
        if (kind != prev) cnt = 0;
        cnt++;
        bus.mem_ack = (cnt == mem_lat);
      end
      prev = kind;
    end
  end

  // Completion monitor
  initial begin
    done_t e;
    forever begin
      @(negedge clk);
      if (bus.done !== '0) begin
        if (done_q.size() == 0) check("done_unexpected", done_q.size(), 1);
        else begin
          e = done_q.pop_front();
          check("done_vec", bus.done, e.done_v);
          check("c_in", bus.C_in, e.c_v);
          if (e.cyc >= 0) check("done_cycle", cyc, e.cyc);
        end
      end else if (bus.C_in !== '0) begin
        check("c_in_without_done", bus.C_in, 0);
      end
    end
  end

  // Broadcast monitor
  initial begin
    bcast_t e;
    forever begin
      @(negedge clk);
      if ((bus.BusRd_in | bus.BusRdX_in | bus.BusUpgr_in) !== '0) begin
        if (bcast_q.size() == 0) check("bcast_unexpected", bcast_q.size(), 1);
        else begin
          e = bcast_q.pop_front();
          check("busrd_in", bus.BusRd_in, e.rd_v);
          check("busrdx_in", bus.BusRdX_in, e.rdx_v);
          check("busupgr_in", bus.BusUpgr_in, e.upgr_v);
          check("snoop_addr", bus.snoop_addr, e.addr);
        end
      end
    end
  end

  task automatic mem_end(input logic is_wr, input logic [AW-1:0] a, input int n);
    mem_t e;
    if (mem_q.size() == 0) check("mem_unexpected", mem_q.size(), 1);
    else begin
      e = mem_q.pop_front();
      check("mem_kind_wr", is_wr, e.is_wr);
      check("mem_addr", a, e.addr);
      check("mem_req_cycles", n, e.cycles);
    end
  endtask

  // Memory request monitor: one comparison set per completed request level
  initial begin
    int wr_run = 0;
    int rd_run = 0;
    logic [AW-1:0] wr_a, rd_a;
    wr_a = '0;
    rd_a = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_wr_req) begin
        if (wr_run == 0) wr_a = bus.mem_addr;
        wr_run++;
      end else if (wr_run > 0) begin
        mem_end(1'b1, wr_a, wr_run);
        wr_run = 0;
      end
      if (bus.mem_rd_req) begin
        if (rd_run == 0) rd_a = bus.mem_addr;
        rd_run++;
      end else if (rd_run > 0) begin
        mem_end(1'b0, rd_a, rd_run);
        rd_run = 0;
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int c, input logic rd, input logic rdx, input logic upgr,
                       input logic [AW-1:0] a);
    bus.BusRd_out[c]          = rd;
    bus.BusRdX_out[c]         = rdx;
    bus.BusUpgr_out[c]        = upgr;
    bus.req_addr[c*AW +: AW]  = a;
  endtask

  // A cache drops its request once it has seen its done pulse.
  task automatic tick();
    @(negedge clk);
    if (bus.done !== '0) begin
      bus.BusRd_out   = bus.BusRd_out & ~bus.done;
      bus.BusRdX_out  = bus.BusRdX_out & ~bus.done;
      bus.BusUpgr_out = bus.BusUpgr_out & ~bus.done;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_done(input int c, input int budget);
    logic seen;
    logic hit;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      hit = bus.done[c];
      bus.BusRd_out   = bus.BusRd_out & ~bus.done;
      bus.BusRdX_out  = bus.BusRdX_out & ~bus.done;
      bus.BusUpgr_out = bus.BusUpgr_out & ~bus.done;
      if (hit) begin
        seen = 1'b1;
        break;
      end
    end
    check($sformatf("done_seen_cache%0d", c), seen, 1'b1);
  endtask

  task automatic expect_txn(input int c, input bus_cmd_e cmd, input logic [N-1:0] bv,
                            input logic [AW-1:0] a, input logic wb, input logic fill,
                            input int lat, input logic [N-1:0] c_exp, input int exp_cyc);
    bcast_t b;
    mem_t   m;
    done_t  d;
    b.rd_v   = (cmd == CMD_RD)   ? bv : '0;
    b.rdx_v  = (cmd == CMD_RDX)  ? bv : '0;
    b.upgr_v = (cmd == CMD_UPGR) ? bv : '0;
    b.addr   = a;
    bcast_q.push_back(b);
    if (wb) begin
      m.is_wr = 1'b1; m.addr = a; m.cycles = lat;
      mem_q.push_back(m);
    end
    if (fill) begin
      m.is_wr = 1'b0; m.addr = a; m.cycles = lat;
      mem_q.push_back(m);
    end
    d.done_v = N'(1) << c;
    d.c_v    = c_exp;
    d.cyc    = exp_cyc;
    done_q.push_back(d);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_bcast"}, {bus.BusRd_in, bus.BusRdX_in, bus.BusUpgr_in}, 0);
    check({tag, "_done_cin"}, {bus.done, bus.C_in}, 0);
    check({tag, "_mem_req"}, {bus.mem_rd_req, bus.mem_wr_req}, 0);
    check({tag, "_snoop_addr"}, bus.snoop_addr, 0);
    check({tag, "_mem_addr"}, bus.mem_addr, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    bcast_t b;
    mem_t   m;
    logic   seen;
    rstb            = 1'b1;
    bus.BusRd_out   = '0;
    bus.BusRdX_out  = '0;
    bus.BusUpgr_out = '0;
    bus.req_addr    = '0;
    bus.snoop_hit   = '0;
    bus.Flush       = '0;
    #3 rstb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rstb = 1'b1;
    idle_cycles(2);

    // Cache0 BusRd, no sharers, 3-cycle fill
    sync();
    mem_lat = 3;
    t0 = cyc;
    expect_txn(0, CMD_RD, 4'b1110, 32'h1000_0040, 1'b0, 1'b1, 3, 4'b0000, t0 + 7);
    issue(0, 1'b1, 1'b0, 1'b0, 32'h1000_0040);
    wait_done(0, 40);

    // Cache1 BusRd, cache2 holds the line; cache1's own hit bit must be masked
    sync();
    bus.snoop_hit = 4'b0110;
    t0 = cyc;
    expect_txn(1, CMD_RD, 4'b1101, 32'h2000_0080, 1'b0, 1'b1, 3, 4'b0010, t0 + 7);
    issue(1, 1'b1, 1'b0, 1'b0, 32'h2000_0080);
    wait_done(1, 40);

    // Cache2 BusUpgr with BusRd also set: upgrade wins, no memory, 4 cycles
    sync();
    bus.snoop_hit = 4'b1111;
    t0 = cyc;
    expect_txn(2, CMD_UPGR, 4'b1011, 32'h3000_00C0, 1'b0, 1'b0, 3, 4'b0000, t0 + 4);
    issue(2, 1'b1, 1'b0, 1'b1, 32'h3000_00C0);
    wait_done(2, 40);

    // Cache3 BusRdX (BusRd also set), cache0 flushes dirty data
    sync();
    bus.snoop_hit = 4'b0001;
    bus.Flush     = 4'b0001;
    t0 = cyc;
    expect_txn(3, CMD_RDX, 4'b0111, 32'h4000_0100, 1'b1, !C2C, 3, 4'b0000,
               t0 + (C2C ? 7 : 10));
    issue(3, 1'b1, 1'b1, 1'b0, 32'h4000_0100);
    wait_done(3, 40);

    // Cache0 BusRd, cache2 flushes; shared only via cache-to-cache transfer
    sync();
    bus.snoop_hit = 4'b0000;
    bus.Flush     = 4'b0100;
    t0 = cyc;
    expect_txn(0, CMD_RD, 4'b1110, 32'h5000_0140, 1'b1, !C2C, 3,
               C2C ? 4'b0001 : 4'b0000, t0 + (C2C ? 7 : 10));
    issue(0, 1'b1, 1'b0, 1'b0, 32'h5000_0140);
    wait_done(0, 40);

    // mem_ack in the same cycle the fill request first appears
    sync();
    bus.Flush = 4'b0000;
    mem_lat   = 1;
    t0 = cyc;
    expect_txn(1, CMD_RD, 4'b1101, 32'h6000_0180, 1'b0, 1'b1, 1, 4'b0000, t0 + 5);
    issue(1, 1'b1, 1'b0, 1'b0, 32'h6000_0180);
    wait_done(1, 40);

    // Idle reset pulse, then caches 0,1,3 request together: grants 0,1,3
    sync();
    rstb = 1'b0;
    #1;
    check_outputs_zero("idle_reset");
    sync();
    rstb    = 1'b1;
    mem_lat = 2;
    sync();
    expect_txn(0, CMD_RD, 4'b1110, 32'h7000_0000, 1'b0, 1'b1, 2, 4'b0000, -1);
    expect_txn(1, CMD_RD, 4'b1101, 32'h7100_0000, 1'b0, 1'b1, 2, 4'b0000, -1);
    expect_txn(3, CMD_RD, 4'b0111, 32'h7300_0000, 1'b0, 1'b1, 2, 4'b0000, -1);
    issue(0, 1'b1, 1'b0, 1'b0, 32'h7000_0000);
    issue(1, 1'b1, 1'b0, 1'b0, 32'h7100_0000);
    issue(3, 1'b1, 1'b0, 1'b0, 32'h7300_0000);
    wait_done(0, 60);
    wait_done(1, 60);
    idle_cycles(3);
    // Cache3 now owns the bus; cache0 re-requests and must be served next
    expect_txn(0, CMD_RD, 4'b1110, 32'h7000_0400, 1'b0, 1'b1, 2, 4'b0000, -1);
    issue(0, 1'b1, 1'b0, 1'b0, 32'h7000_0400);
    wait_done(3, 60);
    wait_done(0, 60);

    // Reset in the middle of a fill; the held request is served again
    sync();
    mem_lat = 10;
    b.rd_v = 4'b1011; b.rdx_v = '0; b.upgr_v = '0; b.addr = 32'h8000_0200;
    bcast_q.push_back(b);
    m.is_wr = 1'b0; m.addr = 32'h8000_0200; m.cycles = 2;
    mem_q.push_back(m);
    issue(2, 1'b1, 1'b0, 1'b0, 32'h8000_0200);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.mem_rd_req) begin
        seen = 1'b1;
        break;
      end
    end
    check("fill_started", seen, 1'b1);
    @(negedge clk);
    #2;
    mem_lat = 3;
    rstb    = 1'b0;
    #1;
    check_outputs_zero("fill_reset");
    check("fill_reset_req_held", bus.BusRd_out[2], 1'b1);
    expect_txn(2, CMD_RD, 4'b1011, 32'h8000_0200, 1'b0, 1'b1, 3, 4'b0000, -1);
    @(negedge clk);
    #2;
    rstb = 1'b1;
    wait_done(2, 60);

    idle_cycles(5);
    check("done_q_drained", done_q.size(), 0);
    check("bcast_q_drained", bcast_q.size(), 0);
    check("mem_q_drained", mem_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
